if_fetch_unit: RTL

- Parametrised instruction-fetch stage: owns the PC and issues one fetch at a time to the icache over a valid/ready request channel.
- Buffers returned instructions, tagged with their PC, in a flushable queue of QUEUE_DEPTH entries.
- Presents the queue head to the decoder with a valid/ready handshake.
- Supports backend redirect (jump/mispredict) with queue flush and in-flight response cancellation. Sits between the icache and the decoder.

---
 rtl/if_fetch_unit_pkg.sv | 11 +
 rtl/if_fetch_unit_queue.sv | 56 +++++
 rtl/if_fetch_unit.sv | 76 +++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_pkg: shared widths, queue entry and fetch FSM state for the fetch unit
package if_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int INST_WIDTH = 32;
  localparam int INST_BYTES = 4;
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [INST_WIDTH-1:0]   instr;
  } fetch_entry_t;
  typedef enum logic {IDLE, WAIT} fetch_state_t;
endpackage

// File: rtl/if_fetch_unit_queue.sv
// fetch_queue: flushable circular FIFO of fetch entries, head read from registers
module fetch_queue
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  entry_t                       push_data,
  output entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d = tail_q + AW'(1);
      end
      head_d = pop ? head_q + AW'(1) : head_q;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  assign head = mem_q[head_q];
  assign count = count_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, single-outstanding icache fetch FSM, redirect/drop handling and instruction queue
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEFAULT,
  parameter int              QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic                               rdy_in,
  output logic                               icache_req_valid,
  output logic [XLEN-1:0]                    icache_req_addr,
  input  logic                               icache_req_ready,
  input  logic                               icache_resp_valid,
  input  logic [INST_WIDTH-1:0]              icache_resp_instr,
  input  logic                               redirect_valid,
  input  logic [XLEN-1:0]                    redirect_pc,
  output logic                               instr_valid,
  output logic [INST_WIDTH-1:0]              instr,
  output logic [XLEN-1:0]                    instr_pc,
  input  logic                               instr_ready,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
);
  localparam int CW = $clog2(QUEUE_DEPTH+1);
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [INST_WIDTH-1:0] instr;
  } entry_t;
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic drop_q, drop_d;
  logic credit, redir, fire, resp, push, pop;
  entry_t head;
  always_comb begin
    // an outstanding request reserves a slot so its response always fits
    credit = ({1'b0, queue_count} + (CW+1)'(state_q == WAIT)) < (CW+1)'(QUEUE_DEPTH);
    redir = rdy_in & redirect_valid;
    icache_req_valid = rst_n_in & rdy_in & state_q == IDLE & credit & !redirect_valid;
    fire = icache_req_valid & icache_req_ready;
    resp = rdy_in & state_q == WAIT & icache_resp_valid;
    push = resp & !drop_q & !redir;
    instr_valid = rdy_in & queue_count != '0;
    pop = instr_valid & instr_ready;
    pc_d = redir ? redirect_pc : fire ? pc_q + XLEN'(INST_BYTES) : pc_q;
    req_pc_d = fire ? pc_q : req_pc_q;
    state_d = fire ? WAIT : resp ? IDLE : state_q;
    drop_d = resp ? 1'b0 : (redir & state_q == WAIT) ? 1'b1 : drop_q;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      req_pc_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q <= drop_d;
    end
  end
  fetch_queue #(.DEPTH(QUEUE_DEPTH), .entry_t(entry_t)) u_queue (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (push),
    .pop       (pop),
    .flush     (redir),
    .push_data ('{pc: req_pc_q, instr: icache_resp_instr}),
    .head      (head),
    .count     (queue_count)
  );
  assign icache_req_addr = pc_q;
  assign instr = head.instr;
  assign instr_pc = head.pc;
endmodule
